// File: rtl/risc_v_rob_mc.sv
// Reorder buffer with multi-channel writeback and multi-slot in-order commit.
//
// Ports:
//   clk, globalReset            clock; asynchronous active-high reset
//   alloc_req/ctrl/dest         dispatch request, control-flow flag, destination register
//   alloc_tag                   tag granted to the dispatch (current tail)
//   full, empty                 occupancy flags
//   wb_valid/mispredict/tag/value/target   NWB packed writeback channels
//   rd_tag1/2 -> rd_value1/2, rd_valid1/2  operand lookup with same-cycle writeback bypass
//   commit_valid/dest/value/tag CW packed commit slots, registered
//   flush, flush_pc             one-cycle redirect after a mispredicted commit
module risc_v_rob_mc #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned REG   = 4,
    parameter int unsigned TAGW  = 3,
    parameter int unsigned NWB   = 2,
    parameter int unsigned CW    = 2
) (
    input  logic                   clk,
    input  logic                   globalReset,
    input  logic                   alloc_req,
    input  logic                   alloc_ctrl,
    input  logic [REG:0]           alloc_dest,
    output logic [TAGW-1:0]        alloc_tag,
    output logic                   full,
    output logic                   empty,
    input  logic [NWB-1:0]         wb_valid,
    input  logic [NWB-1:0]         wb_mispredict,
    input  logic [NWB*TAGW-1:0]    wb_tag,
    input  logic [NWB*(WIDTH+1)-1:0] wb_value,
    input  logic [NWB*(WIDTH+1)-1:0] wb_target,
    input  logic [TAGW-1:0]        rd_tag1,
    input  logic [TAGW-1:0]        rd_tag2,
    output logic [WIDTH:0]         rd_value1,
    output logic [WIDTH:0]         rd_value2,
    output logic                   rd_valid1,
    output logic                   rd_valid2,
    output logic [CW-1:0]          commit_valid,
    output logic [CW*(REG+1)-1:0]  commit_dest,
    output logic [CW*(WIDTH+1)-1:0] commit_value,
    output logic [CW*TAGW-1:0]     commit_tag,
    output logic                   flush,
    output logic [WIDTH:0]         flush_pc
);
    localparam int unsigned DEPTH = 2 ** TAGW;
    localparam int unsigned DW    = WIDTH + 1;
    localparam int unsigned RW    = REG + 1;

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [TAGW:0]    head_q, tail_q, head_next;
    logic [DEPTH-1:0] busy_q, ready_q, misp_q, ctrl_q;
    logic [RW-1:0]    dest_q   [DEPTH];
    logic [DW-1:0]    value_q  [DEPTH];
    logic [DW-1:0]    target_q [DEPTH];

    logic [CW-1:0]       commit_valid_q;
    logic [CW*RW-1:0]    commit_dest_q;
    logic [CW*DW-1:0]    commit_value_q;
    logic [CW*TAGW-1:0]  commit_tag_q;
    logic                flush_q;
    logic [DW-1:0]       flush_pc_q;

    logic [TAGW-1:0] wb_tag_a    [NWB];
    logic [DW-1:0]   wb_value_a  [NWB];
    logic [DW-1:0]   wb_target_a [NWB];

    always_comb begin
        for (int c = 0; c < int'(NWB); c++) begin
            wb_tag_a[c]    = wb_tag[c*TAGW +: TAGW];
            wb_value_a[c]  = wb_value[c*DW +: DW];
            wb_target_a[c] = wb_target[c*DW +: DW];
        end
    end

    assign empty      = (head_q == tail_q);
    assign full       = (head_q[TAGW] != tail_q[TAGW]) &&
                        (head_q[TAGW-1:0] == tail_q[TAGW-1:0]);
    assign alloc_tag  = tail_q[TAGW-1:0];

    logic alloc_fire;
    assign alloc_fire = alloc_req && !full;

    // Commit selection: contiguous ready run from head, cut after a mispredicted slot.
    logic [CW-1:0]   go;
    logic [TAGW-1:0] slot_idx [CW];
    logic [TAGW:0]   n_commit;
    logic            misp_hit;
    logic [DW-1:0]   misp_target;
    logic            stop;

    always_comb begin
        go          = '0;
        n_commit    = '0;
        misp_hit    = 1'b0;
        misp_target = '0;
        stop        = 1'b0;
        for (int k = 0; k < int'(CW); k++) begin
            slot_idx[k] = head_q[TAGW-1:0] + TAGW'(k);
            if (!stop && busy_q[slot_idx[k]] && ready_q[slot_idx[k]]) begin
                go[k]    = 1'b1;
                n_commit = (TAGW+1)'(k + 1);
                if (misp_q[slot_idx[k]]) begin
                    misp_hit    = 1'b1;
                    misp_target = target_q[slot_idx[k]];
                    stop        = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign head_next = head_q + n_commit;

    // Stored result wins; otherwise bypass from the lowest matching writeback channel.
    function automatic logic [DW:0] rd_lookup(input logic [TAGW-1:0] tag);
        logic [DW:0] r;
        r = {1'b0, {DW{1'b0}}};
        if (ready_q[tag]) begin
            r = {1'b1, value_q[tag]};
        end else begin
            for (int c = int'(NWB) - 1; c >= 0; c--) begin
                if (wb_valid[c] && (wb_tag_a[c] == tag)) r = {1'b1, wb_value_a[c]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {rd_valid1, rd_value1} = rd_lookup(rd_tag1);
        {rd_valid2, rd_value2} = rd_lookup(rd_tag2);
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            head_q         <= '0;
            tail_q         <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            misp_q         <= '0;
            ctrl_q         <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            commit_valid_q <= '0;
            commit_dest_q  <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q <= head_next;
            for (int k = 0; k < int'(CW); k++) begin
                commit_valid_q[k]            <= go[k];
                commit_dest_q[k*RW +: RW]    <= go[k] ? dest_q[slot_idx[k]] : '0;
                commit_value_q[k*DW +: DW]   <= go[k] ? value_q[slot_idx[k]] : '0;
                commit_tag_q[k*TAGW +: TAGW] <= go[k] ? slot_idx[k] : '0;
            end
            flush_q    <= misp_hit;
            flush_pc_q <= misp_hit ? misp_target : '0;

            if (misp_hit) begin
                // Squash everything younger; allocation and writebacks this cycle are dropped.
                tail_q  <= head_next;
                busy_q  <= '0;
                ready_q <= '0;
                misp_q  <= '0;
            end else begin
                // Descending order so the lowest channel's write lands last.
                for (int c = int'(NWB) - 1; c >= 0; c--) begin
                    if (wb_valid[c] && busy_q[wb_tag_a[c]]) begin
                        ready_q[wb_tag_a[c]]  <= 1'b1;
                        value_q[wb_tag_a[c]]  <= wb_value_a[c];
                        target_q[wb_tag_a[c]] <= wb_target_a[c];
                        // Only control-flow entries can redirect.
                        misp_q[wb_tag_a[c]]   <= wb_mispredict[c] & ctrl_q[wb_tag_a[c]];
                    end
                end
                if (alloc_fire) begin
                    busy_q[tail_q[TAGW-1:0]]  <= 1'b1;
                    ready_q[tail_q[TAGW-1:0]] <= 1'b0;
                    misp_q[tail_q[TAGW-1:0]]  <= 1'b0;
                    ctrl_q[tail_q[TAGW-1:0]]  <= alloc_ctrl;
                    dest_q[tail_q[TAGW-1:0]]  <= alloc_dest;
                    tail_q                    <= tail_q + (TAGW+1)'(1);
                end
                for (int k = 0; k < int'(CW); k++) begin
                    if (go[k]) begin
                        busy_q[slot_idx[k]]  <= 1'b0;
                        ready_q[slot_idx[k]] <= 1'b0;
                    end
                end
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_dest  = commit_dest_q;
    assign commit_value = commit_value_q;
    assign commit_tag   = commit_tag_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_risc_v_rob_mc.sv
module tb_risc_v_rob_mc;
    logic        clk = 1'b0;
    logic        globalReset;
    logic        alloc_req, alloc_ctrl;
    logic [4:0]  alloc_dest;
    logic [2:0]  alloc_tag;
    logic        full, empty;
    logic [1:0]  wb_valid, wb_mispredict;
    logic [5:0]  wb_tag;
    logic [63:0] wb_value, wb_target;
    logic [2:0]  rd_tag1, rd_tag2;
    logic [31:0] rd_value1, rd_value2;
    logic        rd_valid1, rd_valid2;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_dest;
    logic [63:0] commit_value;
    logic [5:0]  commit_tag;
    logic        flush;
    logic [31:0] flush_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc_v_rob_mc dut (
        .clk          (clk),
        .globalReset  (globalReset),
        .alloc_req    (alloc_req),
        .alloc_ctrl   (alloc_ctrl),
        .alloc_dest   (alloc_dest),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .empty        (empty),
        .wb_valid     (wb_valid),
        .wb_mispredict(wb_mispredict),
        .wb_tag       (wb_tag),
        .wb_value     (wb_value),
        .wb_target    (wb_target),
        .rd_tag1      (rd_tag1),
        .rd_tag2      (rd_tag2),
        .rd_value1    (rd_value1),
        .rd_value2    (rd_value2),
        .rd_valid1    (rd_valid1),
        .rd_valid2    (rd_valid2),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_value (commit_value),
        .commit_tag   (commit_tag),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_in();
        alloc_req     = 1'b0;
        alloc_ctrl    = 1'b0;
        alloc_dest    = '0;
        wb_valid      = '0;
        wb_mispredict = '0;
        wb_tag        = '0;
        wb_value      = '0;
        wb_target     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int ch, input logic [2:0] tag, input logic [31:0] val,
                          input logic m, input logic [31:0] tgt);
        wb_valid[ch]           = 1'b1;
        wb_mispredict[ch]      = m;
        wb_tag[ch*3 +: 3]      = tag;
        wb_value[ch*32 +: 32]  = val;
        wb_target[ch*32 +: 32] = tgt;
    endtask

    task automatic alloc(input logic [4:0] dest, input logic ctrl, input logic [2:0] exp_tag,
                         input string tag);
        alloc_req  = 1'b1;
        alloc_dest = dest;
        alloc_ctrl = ctrl;
        #1;
        chk(tag, {61'd0, alloc_tag}, {61'd0, exp_tag});
        tick();
        clear_in();
    endtask

    task automatic do_reset();
        #2;
        globalReset = 1'b1;
        tick();
        #2;
        globalReset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  t0, t1;
        logic [31:0] v0, v1;
        logic [4:0]  d0, d1;

        clear_in();
        rd_tag1     = '0;
        rd_tag2     = '0;
        globalReset = 1'b1;
        tick();
        tick();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        #2;
        globalReset = 1'b0;

        // Fill all eight entries, then try a ninth.
        for (int i = 0; i < 8; i++) alloc(5'(i + 1), 1'b0, 3'(i), "fill_tag");
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_not_empty", 64'(empty), 64'd0);
        alloc_req = 1'b1;
        tick();
        clear_in();
        chk("ninth_ignored_tag", 64'(alloc_tag), 64'd0);
        chk("ninth_still_full", 64'(full), 64'd1);

        // Dual commit after out-of-order writeback on two channels.
        do_reset();
        chk("reset_clears_full", 64'(full), 64'd0);
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0, 3'(i), "dual_alloc");
        set_wb(0, 3'd1, 32'h11, 1'b0, 32'h0);
        set_wb(1, 3'd0, 32'h10, 1'b0, 32'h0);
        tick();
        clear_in();
        chk("dual_not_yet", 64'(commit_valid), 64'd0);
        tick();
        chk("dual_valid", 64'(commit_valid), 64'd3);
        chk("dual_value", commit_value, {32'h11, 32'h10});
        chk("dual_tag", 64'(commit_tag), 64'({3'd1, 3'd0}));
        chk("dual_dest", 64'(commit_dest), 64'({5'd2, 5'd1}));
        tick();
        chk("dual_once", 64'(commit_valid), 64'd0);

        // Tag3 ready while head (tag2) is pending: nothing may commit.
        set_wb(0, 3'd3, 32'h33, 1'b0, 32'h0);
        tick();
        clear_in();
        tick();
        chk("order_blocked1", 64'(commit_valid), 64'd0);
        tick();
        chk("order_blocked2", 64'(commit_valid), 64'd0);
        set_wb(1, 3'd2, 32'h22, 1'b0, 32'h0);
        tick();
        clear_in();
        tick();
        chk("order_valid", 64'(commit_valid), 64'd3);
        chk("order_value", commit_value, {32'h33, 32'h22});
        chk("order_tag", 64'(commit_tag), 64'({3'd3, 3'd2}));
        tick();
        chk("order_empty", 64'(empty), 64'd1);

        // Mispredicted branch at the head squashes younger entries.
        do_reset();
        alloc(5'd1, 1'b1, 3'd0, "mp_alloc0");
        alloc(5'd2, 1'b0, 3'd1, "mp_alloc1");
        alloc(5'd3, 1'b0, 3'd2, "mp_alloc2");
        alloc(5'd4, 1'b0, 3'd3, "mp_alloc3");
        set_wb(0, 3'd0, 32'h100, 1'b1, 32'h40);
        set_wb(1, 3'd1, 32'h101, 1'b0, 32'h0);
        tick();
        clear_in();
        set_wb(0, 3'd2, 32'h102, 1'b0, 32'h0);
        set_wb(1, 3'd3, 32'h103, 1'b0, 32'h0);
        tick();
        clear_in();
        chk("mp_commit_valid", 64'(commit_valid), 64'd1);
        chk("mp_commit_tag", 64'(commit_tag), 64'd0);
        chk("mp_commit_value", commit_value, 64'h100);
        chk("mp_flush", 64'(flush), 64'd1);
        chk("mp_flush_pc", 64'(flush_pc), 64'h40);
        chk("mp_empty", 64'(empty), 64'd1);
        chk("mp_tail", 64'(alloc_tag), 64'd1);
        tick();
        chk("mp_flush_one_cycle", 64'(flush), 64'd0);
        chk("mp_after_valid", 64'(commit_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mp_squashed_never", 64'(commit_valid), 64'd0);
        end

        // Bypass and same-tag channel priority.
        alloc(5'd5, 1'b1, 3'd1, "byp_alloc");
        alloc(5'd6, 1'b0, 3'd2, "byp_alloc");
        alloc(5'd7, 1'b0, 3'd3, "byp_alloc");
        alloc(5'd8, 1'b0, 3'd4, "byp_alloc");
        alloc(5'd9, 1'b0, 3'd5, "byp_alloc");
        rd_tag1 = 3'd5;
        rd_tag2 = 3'd4;
        set_wb(1, 3'd5, 32'hDEAD, 1'b0, 32'h0);
        #1;
        chk("byp_valid1", 64'(rd_valid1), 64'd1);
        chk("byp_value1", 64'(rd_value1), 64'hDEAD);
        chk("byp_valid2_none", 64'(rd_valid2), 64'd0);
        chk("byp_value2_none", 64'(rd_value2), 64'd0);
        tick();
        clear_in();
        set_wb(0, 3'd4, 32'hA, 1'b0, 32'h0);
        set_wb(1, 3'd4, 32'hB, 1'b0, 32'h0);
        #1;
        chk("prio_bypass", 64'(rd_value2), 64'hA);
        tick();
        clear_in();
        #1;
        chk("prio_stored", 64'(rd_value2), 64'hA);
        chk("prio_stored_valid", 64'(rd_valid2), 64'd1);
        chk("byp_stored1", 64'(rd_value1), 64'hDEAD);
        chk("byp_no_commit", 64'(commit_valid), 64'd0);

        // Six busy entries with a flush armed, then asynchronous reset.
        alloc_req  = 1'b1;
        alloc_dest = 5'd10;
        set_wb(0, 3'd1, 32'h1, 1'b1, 32'h80);
        #1;
        chk("pend_alloc_tag", 64'(alloc_tag), 64'd6);
        tick();
        clear_in();
        chk("pend_not_empty", 64'(empty), 64'd0);
        #2;
        globalReset = 1'b1;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("arst_rd_valid", 64'(rd_valid1), 64'd0);
        chk("arst_full", 64'(full), 64'd0);
        alloc_req = 1'b1;
        tick();
        clear_in();
        chk("arst_alloc_ignored", 64'(alloc_tag), 64'd0);
        chk("arst_still_empty", 64'(empty), 64'd1);
        #2;
        globalReset = 1'b0;
        tick();
        chk("arst_no_flush", 64'(flush), 64'd0);

        // Ten alloc/commit rounds carry pointers through the wrap.
        for (int r = 0; r < 10; r++) begin
            t0 = 3'(2 * r);
            t1 = 3'(2 * r + 1);
            v0 = 32'h1000 + 32'(2 * r);
            v1 = 32'h1000 + 32'(2 * r + 1);
            d0 = 5'(r + 1);
            d1 = 5'(r + 17);
            alloc(d0, 1'b0, t0, "wrap_alloc0");
            alloc(d1, 1'b0, t1, "wrap_alloc1");
            set_wb(0, t1, v1, 1'b0, 32'h0);
            set_wb(1, t0, v0, 1'b0, 32'h0);
            tick();
            clear_in();
            tick();
            chk("wrap_valid", 64'(commit_valid), 64'd3);
            chk("wrap_tag", 64'(commit_tag), 64'({t1, t0}));
            chk("wrap_value", commit_value, {v1, v0});
            chk("wrap_dest", 64'(commit_dest), 64'({d1, d0}));
            tick();
            chk("wrap_empty", 64'(empty), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/risc_v_rob_mc.md
RISC_V_ROB_MC -- requirements
Module: risc_v_rob_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 31, data/PC MSB index (32-bit values).
REQ-002 SHALL provide parameter REG, default 4, architectural register index MSB.
REQ-003 SHALL provide parameter TAGW, default 3, tag width; depth DEPTH = 2**TAGW entries.
REQ-004 SHALL provide parameter NWB, default 2, number of writeback (common data bus) channels.
REQ-005 SHALL provide parameter CW, default 2, maximum commits per cycle (1..CW).
REQ-006 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have: globalReset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have: alloc_req, alloc_ctrl  input  1 each  dispatch request; entry is control-flow.
REQ-009 SHALL have: alloc_dest  input  REG+1  destination register; alloc_tag  output  TAGW  tag granted (tail).
REQ-010 SHALL have: full, empty  output  1 each  occupancy flags.
REQ-011 SHALL have: wb_valid, wb_mispredict  input  NWB each; wb_tag  input  NWB*TAGW; wb_value, wb_target  input  NWB*(WIDTH+1).
REQ-012 SHALL have: rd_tag1, rd_tag2  input  TAGW; rd_value1, rd_value2  output  WIDTH+1; rd_valid1, rd_valid2  output  1.
REQ-013 SHALL have: commit_valid  output  CW; commit_dest  output  CW*(REG+1); commit_value  output  CW*(WIDTH+1); commit_tag  output  CW*TAGW.
REQ-014 SHALL have: flush  output  1; flush_pc  output  WIDTH+1  redirect target.

Function
REQ-015 SHALL be a circular buffer with head/tail pointers of TAGW+1 bits (extra wrap bit); full = pointers equal except wrap bit; empty = pointers fully equal.
REQ-016 SHALL accept allocation on an edge where alloc_req=1 and full=0: write entry(tail) busy=1, ready=0, mispredict=0, dest, ctrl; tail+1; alloc_tag = tail[TAGW-1:0] combinationally.
REQ-017 SHALL ignore alloc_req while full=1; full evaluated from start-of-cycle pointers (a same-cycle commit does not free a slot for that cycle's allocation).
REQ-018 SHALL, per wb channel with wb_valid=1 targeting a busy entry, set ready=1 and store value, mispredict, target; writeback to a non-busy entry is ignored.
REQ-019 SHALL, when two channels write the same tag in one cycle, take the lowest-indexed channel.
REQ-020 SHALL return rd_value/rd_valid combinationally: valid=1 if entry ready, or bypass from any same-cycle wb channel matching rd_tag (lowest index priority); else valid=0, value=0.
REQ-021 SHALL commit in program order from head: slot k (0..CW-1) commits only if slots 0..k-1 commit and entry head+k is busy and ready.
REQ-022 SHALL register commit outputs: commit_valid[k]/dest/value/tag valid in the cycle after the committing edge; zero when not valid.
REQ-023 SHALL free committed entries (busy=0) and advance head by number committed at the same edge.
REQ-024 SHALL, when a committing slot has mispredict=1, commit that slot, suppress all later slots, clear all busy bits, set tail=head=post-commit head, drop any same-cycle allocation and writebacks, and assert flush=1, flush_pc=its target for exactly one cycle.
REQ-025 SHALL wrap pointers modulo 2*DEPTH with no lost or duplicated entries across the wrap.

Reset
REQ-026 SHALL, on globalReset=1 (asynchronously, any time incl. mid-flush), set head=tail=0, all busy/ready/mispredict=0, commit_valid=0, commit data=0, flush=0, flush_pc=0; empty=1, full=0.
REQ-027 SHALL ignore all inputs while globalReset=1 and resume normal operation on the first rising edge after deassertion.

Verification
REQ-028 Dispatch 8 (DEPTH=8) without writeback -> full=1, alloc_tag sequence 0..7, 9th alloc_req ignored, tail unchanged.
REQ-029 Fill tags 0..3, writeback tag1=0x11, tag0=0x10 same cycle on channels 0/1 -> next cycle commit_valid=2'b11, commit_value {0x11,0x10}, tags {1,0}; head=2.
REQ-030 Writeback tag3 only while tag2 pending -> commit_valid=0 until tag2 written, then both commit same cycle.
REQ-031 Entry 0 ctrl, mispredict=1, target=0x0000_0040, entries 1..3 ready -> only tag0 commits, flush=1 one cycle, flush_pc=0x40, empty=1, entries 1..3 never commit.
REQ-032 rd_tag1=5 while channel 1 writes tag5=0xDEAD in same cycle -> rd_valid1=1, rd_value1=0xDEAD combinationally; same tag on both channels (0xA, 0xB) -> stored 0xA.
REQ-033 Assert globalReset mid-cycle with 6 entries busy and flush pending -> outputs clear immediately without clk edge, empty=1, flush=0; 10 further alloc/commit rounds wrap pointers with correct order.
